seg7_scan_decoder: RTL

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/seg7_scan_decoder_if.sv | 26 ++
 rtl/seg7_glyph_decode.sv | 21 ++
 rtl/seg7_scan_decoder.sv | 135 +++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared glyph table, blank pattern and scan FSM states for the 7-segment scan decoder
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low a..g (bit6..bit0); entry i is the glyph for hex digit i.
    localparam logic [6:0] GLYPH [0:15] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } seg7_state_e;

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// rtl/seg7_scan_decoder_if.sv - scan inputs and decoded outputs; err_cnt present with SEG7_DEC_ERR_CNT_EN
interface seg7_scan_decoder_if #(
    parameter int NDIG = 4
);
    logic [6:0]        seg;
    logic [NDIG-1:0]   dig_sel;
    logic [4*NDIG-1:0] value;
    logic [NDIG-1:0]   dig_vld;
    logic              upd;
    logic [2:0]        upd_idx;
    logic [3:0]        upd_hex;
    logic              err;
`ifdef SEG7_DEC_ERR_CNT_EN
    logic [7:0]        err_cnt;

    modport master (output seg, dig_sel,
                    input  value, dig_vld, upd, upd_idx, upd_hex, err, err_cnt);
    modport slave  (input  seg, dig_sel,
                    output value, dig_vld, upd, upd_idx, upd_hex, err, err_cnt);
`else
    modport master (output seg, dig_sel,
                    input  value, dig_vld, upd, upd_idx, upd_hex, err);
    modport slave  (input  seg, dig_sel,
                    output value, dig_vld, upd, upd_idx, upd_hex, err);
`endif
endinterface

// File: rtl/seg7_glyph_decode.sv
// rtl/seg7_glyph_decode.sv - combinational 7-segment pattern to hex nibble lookup with legality flag
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pat,
    output logic [3:0] hex,
    output logic       legal
);

    always_comb begin
        hex   = 4'd0;
        legal = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pat == GLYPH[i]) begin
                hex   = 4'(i);
                legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - debounces a multiplexed 7-segment scan into per-digit hex values
// Optional SEG7_DEC_ERR_CNT_EN adds a saturating count of illegal-glyph events.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    seg7_scan_decoder_if.slave  bus
);

    logic [6:0]        s_seg, p_seg;
    logic [NDIG-1:0]   s_dig;
    logic [2:0]        s_idx, p_idx;
    logic [3:0]        cnt, cnt_nxt;
    seg7_state_e       state, state_nxt;
    logic              sel_ok, same, commit, upd_set, err_set;
    logic [3:0]        dec_hex;
    logic              dec_legal;
    logic [4*NDIG-1:0] value_q;
    logic [NDIG-1:0]   vld_q;
    logic              upd_q, err_q;
    logic [2:0]        upd_idx_q;
    logic [3:0]        upd_hex_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_seg <= SEG_BLANK;
            s_dig <= '1;
        end else begin
            s_seg <= bus.seg;
            s_dig <= bus.dig_sel;
        end
    end

    always_comb begin
        s_idx = 3'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (!s_dig[i]) s_idx = 3'(i);
        end
    end

    assign sel_ok = $onehot(~s_dig);
    assign same   = (s_seg == p_seg) && (s_idx == p_idx);

    seg7_glyph_decode u_dec (
        .pat   (s_seg),
        .hex   (dec_hex),
        .legal (dec_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            p_seg <= SEG_BLANK;
            p_idx <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            p_seg <= s_seg;
            p_idx <= s_idx;
        end
    end

    // Reaching STABLE_CNT moves straight to HOLD so the commit lands on that edge.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!sel_ok) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else if (state == ST_HOLD && same) begin
            state_nxt = ST_HOLD;
        end else begin
            cnt_nxt   = (state == ST_TRACK && same) ? cnt + 4'd1 : 4'd1;
            state_nxt = (cnt_nxt == 4'(STABLE_CNT)) ? ST_HOLD : ST_TRACK;
        end
    end

    always_comb begin
        commit  = sel_ok && (state_nxt == ST_HOLD) && !(state == ST_HOLD && same);
        upd_set = commit && dec_legal;
        err_set = commit && !dec_legal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q   <= '0;
            vld_q     <= '0;
            upd_q     <= 1'b0;
            err_q     <= 1'b0;
            upd_idx_q <= 3'd0;
            upd_hex_q <= 4'd0;
        end else begin
            upd_q <= upd_set;
            err_q <= err_set;
            if (upd_set) begin
                upd_idx_q <= s_idx;
                upd_hex_q <= dec_hex;
                for (int i = 0; i < NDIG; i++) begin
                    if (3'(i) == s_idx) begin
                        value_q[4*i +: 4] <= dec_hex;
                        vld_q[i]          <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.value   = value_q;
    assign bus.dig_vld = vld_q;
    assign bus.upd     = upd_q;
    assign bus.upd_idx = upd_idx_q;
    assign bus.upd_hex = upd_hex_q;
    assign bus.err     = err_q;

`ifdef SEG7_DEC_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else if (err_set && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
`endif

endmodule
